stall_controller: RTL and testbench
===================================

// Module: stall_controller
// PURPOSE
//  Parametrised pipeline stall/flush controller; successor to the single-counter hazard unit.
//  Classifies the ID-stage instruction (multi-cycle divide, load-use, control transfer).
//  Drives PC/IF-ID enables, IF-ID flush and ID-EX bubble with a per-class cycle count.
//  Sits between the IF/ID register and the PC/pipeline-register enables of the 5-stage MIPS core.
// PARAMETERS
//  DIV_LAT  32  stall cycles for DIV/DIVU (funct 26/27); 0 disables the class
//  LU_LAT   1   stall cycles for load-use; 0 disables load-use detection
//  BR_PEN   2   flush cycles after BEQ/BNE (opcode 4/5)
//  J_PEN    2   flush cycles after J/JAL (opcode 2/3) and JR (opcode 0, funct 8)
//  CNT_W    7   width of the stall counter; every latency must be < 2**CNT_W
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous reset, active-low
//  instr_id     in   32     instruction currently in the IF/ID register
//  ex_memread   in   1      the instruction in ID/EX is a load
//  ex_rt        in   5      destination register of the ID/EX load
//  en_pc        out  1      PC write enable
//  en_ifid      out  1      IF/ID register write enable
//  flush_ifid   out  1      load NOP into IF/ID at the next edge
//  bubble_idex  out  1      load NOP into ID/EX at the next edge
//  hazard       out  1      any stall or flush is active this cycle
//  stall_cnt    out  CNT_W  cycles remaining in the current event, including this one; 0 when idle
//  stall_kind   out  2      0 none, 1 div, 2 load-use, 3 control
// BEHAVIOUR
//  Reset, and every cycle with rst==0: state=IDLE, cnt=0. Outputs are forced to
//   en_pc=1, en_ifid=1, flush_ifid=0, bubble_idex=0, hazard=0, stall_cnt=0, stall_kind=0.
//  Classification (IDLE only), priority div > load-use > control:
//   div:      opcode==0 && funct in {26,27} && DIV_LAT>0
//   loaduse:  LU_LAT>0 && ex_memread && ex_rt!=0 && (ex_rt==rs || ex_rt==rt) of instr_id
//   control:  opcode in {2,3,4,5} or JR. instr_id==0 (NOP) never triggers.
//  FSM states: IDLE, STALL, FLUSH, RELEASE.
//  IDLE, no hit: all enables 1, hazard 0.
//  IDLE, hit of length L: outputs take the event value in the same cycle (Mealy); hazard=1;
//   stall_cnt=L. At the edge: cnt<=L-1. If L==1, go to RELEASE (div/load-use) or IDLE (control).
//   Otherwise go to STALL (div/load-use) or FLUSH (control).
//  STALL: en_pc=0, en_ifid=0, bubble_idex=1, flush_ifid=0; stall_cnt=cnt.
//   cnt decrements each edge. At cnt==1, the next state is RELEASE.
//   Total stall = L cycles, counting the detection cycle.
//  RELEASE: exactly one cycle. All enables 1, hazard 0, classification suppressed so the
//   held instruction advances without re-triggering. Next state is IDLE.
//  FLUSH: en_pc=0, en_ifid=1, flush_ifid=1, bubble_idex=0; stall_cnt=cnt; at cnt==1 go to IDLE.
//  Inputs in STALL/FLUSH/RELEASE are ignored: no nesting and no pre-emption.
//  Reset asserted mid-event: abort immediately; the next cycle after release is IDLE.
//  cnt is CNT_W wide and never wraps; a latency >= 2**CNT_W is illegal (elaboration assert).
// STRUCTURE
//  Package hazard_pkg holds:
//   OP_RTYPE/OP_J/OP_JAL/OP_BEQ/OP_BNE, FN_DIV/FN_DIVU/FN_JR constants;
//   stall_kind_t and state_t enums.
//  One sub-module, hazard_decode (combinational): instr_id, ex_memread, ex_rt -> kind, length.
//  The top level holds the FSM, counter and output mux.
// TESTING
//  1. rst=0 for 2 cycles with a DIV in ID -> en_pc=1, hazard=0, stall_cnt=0 throughout reset.
//  2. DIV (funct 26), DIV_LAT=32 -> en_pc=0 for exactly 32 cycles, stall_cnt 32..1,
//     then 1 RELEASE cycle with en_pc=1 and no retrigger.
//  3. lw $2 in EX, add $3,$2,$4 in ID -> 1 cycle en_pc=0, bubble_idex=1, kind=2; add proceeds next cycle.
//  4. BEQ in ID, BR_PEN=2 -> flush_ifid=1 and en_pc=0 for 2 cycles, en_ifid=1, then IDLE.
//  5. DIV in ID while a load-use also matches -> kind=1 (div wins), 32-cycle stall.
//  6. rst=0 at stall cycle 10 of a DIV -> all outputs at reset values next cycle;
//     after release, the same DIV restarts a full 32-cycle stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcode/funct constants and enums for the stall/flush controller.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;

    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_DIV  = 2'd1,
        KIND_LU   = 2'd2,
        KIND_CTRL = 2'd3
    } stall_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/stall_controller_if.sv
// ID-stage hazard inputs and pipeline enable/flush outputs of the stall controller.
interface stall_controller_if #(
    parameter int CNT_W = 7
);
    logic [31:0]      instr_id;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             en_pc;
    logic             en_ifid;
    logic             flush_ifid;
    logic             bubble_idex;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       stall_kind;

    modport master (
        output instr_id, ex_memread, ex_rt,
        input  en_pc, en_ifid, flush_ifid, bubble_idex, hazard, stall_cnt, stall_kind
    );

    modport slave (
        input  instr_id, ex_memread, ex_rt,
        output en_pc, en_ifid, flush_ifid, bubble_idex, hazard, stall_cnt, stall_kind
    );
endinterface

// File: rtl/hazard_decode.sv
// Combinational classifier: maps the ID-stage instruction and EX load info to a hazard
// kind and its cycle count, with priority div > load-use > control.
module hazard_decode
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int LU_LAT  = 1,
    parameter int BR_PEN  = 2,
    parameter int J_PEN   = 2,
    parameter int CNT_W   = 7
) (
    input  logic [31:0]      instr_id,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    output stall_kind_t      kind,
    output logic [CNT_W-1:0] length
);

    localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] LU_LEN  = CNT_W'(LU_LAT);
    localparam logic [CNT_W-1:0] BR_LEN  = CNT_W'(BR_PEN);
    localparam logic [CNT_W-1:0] J_LEN   = CNT_W'(J_PEN);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic       instr_nz_s;
    logic       is_div_s;
    logic       is_lu_s;
    logic       is_br_s;
    logic       is_jmp_s;

    assign opcode_s   = instr_id[31:26];
    assign rs_s       = instr_id[25:21];
    assign rt_s       = instr_id[20:16];
    assign funct_s    = instr_id[5:0];
    // An all-zero word is the pipeline NOP and must never raise a hazard.
    assign instr_nz_s = (instr_id != 32'd0);

    assign is_div_s = (opcode_s == OP_RTYPE) && ((funct_s == FN_DIV) || (funct_s == FN_DIVU));
    assign is_lu_s  = ex_memread && (ex_rt != 5'd0) && ((ex_rt == rs_s) || (ex_rt == rt_s));
    assign is_br_s  = (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
    assign is_jmp_s = (opcode_s == OP_J) || (opcode_s == OP_JAL) ||
                      ((opcode_s == OP_RTYPE) && (funct_s == FN_JR));

    // Priority classification; a zero latency parameter disables its class.
    always_comb begin
        kind   = KIND_NONE;
        length = {CNT_W{1'b0}};
        if (instr_nz_s && is_div_s && (DIV_LAT > 32'sd0)) begin
            kind   = KIND_DIV;
            length = DIV_LEN;
        end else if (instr_nz_s && is_lu_s && (LU_LAT > 32'sd0)) begin
            kind   = KIND_LU;
            length = LU_LEN;
        end else if (instr_nz_s && is_br_s && (BR_PEN > 32'sd0)) begin
            kind   = KIND_CTRL;
            length = BR_LEN;
        end else if (instr_nz_s && is_jmp_s && (J_PEN > 32'sd0)) begin
            kind   = KIND_CTRL;
            length = J_LEN;
        end else begin
            kind   = KIND_NONE;
            length = {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: FSM and cycle counter driving PC/IF-ID enables,
// IF-ID flush and ID-EX bubble from the classified ID-stage hazard.
module stall_controller
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int LU_LAT  = 1,
    parameter int BR_PEN  = 2,
    parameter int J_PEN   = 2,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               rst,
    stall_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    if ((DIV_LAT >= (32'sd1 << CNT_W)) || (LU_LAT >= (32'sd1 << CNT_W)) ||
        (BR_PEN >= (32'sd1 << CNT_W)) || (J_PEN >= (32'sd1 << CNT_W))) begin : g_lat_check
        $error("stall_controller: a latency does not fit in CNT_W bits");
    end

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    stall_kind_t      kind_r, kind_nxt_s;
    stall_kind_t      dec_kind_s;
    logic [CNT_W-1:0] dec_len_s;

    logic             en_pc_s, en_ifid_s, flush_s, bubble_s, hazard_s;
    logic [CNT_W-1:0] cnt_out_s;
    stall_kind_t      kind_out_s;

    hazard_decode #(
        .DIV_LAT (DIV_LAT),
        .LU_LAT  (LU_LAT),
        .BR_PEN  (BR_PEN),
        .J_PEN   (J_PEN),
        .CNT_W   (CNT_W)
    ) u_decode (
        .instr_id   (bus.instr_id),
        .ex_memread (bus.ex_memread),
        .ex_rt      (bus.ex_rt),
        .kind       (dec_kind_s),
        .length     (dec_len_s)
    );

    // State, counter and held event kind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            kind_r  <= KIND_NONE;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            kind_r  <= kind_nxt_s;
        end
    end

    // Next-state and Mealy output mux; reset forces the idle outputs in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        kind_nxt_s  = kind_r;
        en_pc_s     = 1'b1;
        en_ifid_s   = 1'b1;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        hazard_s    = 1'b0;
        cnt_out_s   = CNT_ZERO;
        kind_out_s  = KIND_NONE;
        if (!rst) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            kind_nxt_s  = KIND_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dec_kind_s != KIND_NONE) begin
                        hazard_s   = 1'b1;
                        en_pc_s    = 1'b0;
                        cnt_out_s  = dec_len_s;
                        kind_out_s = dec_kind_s;
                        kind_nxt_s = dec_kind_s;
                        cnt_nxt_s  = dec_len_s - CNT_ONE;
                        if (dec_kind_s == KIND_CTRL) begin
                            flush_s     = 1'b1;
                            state_nxt_s = (dec_len_s == CNT_ONE) ? ST_IDLE : ST_FLUSH;
                        end else begin
                            en_ifid_s   = 1'b0;
                            bubble_s    = 1'b1;
                            state_nxt_s = (dec_len_s == CNT_ONE) ? ST_RELEASE : ST_STALL;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    en_pc_s     = 1'b0;
                    en_ifid_s   = 1'b0;
                    bubble_s    = 1'b1;
                    hazard_s    = 1'b1;
                    cnt_out_s   = cnt_r;
                    kind_out_s  = kind_r;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    state_nxt_s = (cnt_r == CNT_ONE) ? ST_RELEASE : ST_STALL;
                end
                ST_FLUSH: begin
                    en_pc_s     = 1'b0;
                    flush_s     = 1'b1;
                    hazard_s    = 1'b1;
                    cnt_out_s   = cnt_r;
                    kind_out_s  = kind_r;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    state_nxt_s = (cnt_r == CNT_ONE) ? ST_IDLE : ST_FLUSH;
                end
                ST_RELEASE: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    kind_nxt_s  = KIND_NONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    kind_nxt_s  = KIND_NONE;
                end
            endcase
        end
    end

    assign bus.en_pc       = en_pc_s;
    assign bus.en_ifid     = en_ifid_s;
    assign bus.flush_ifid  = flush_s;
    assign bus.bubble_idex = bubble_s;
    assign bus.hazard      = hazard_s;
    assign bus.stall_cnt   = cnt_out_s;
    assign bus.stall_kind  = kind_out_s;

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a queue-of-expected-cycles reference model.
module tb_stall_controller;

    localparam int DIV_LAT = 32;
    localparam int LU_LAT  = 1;
    localparam int BR_PEN  = 2;
    localparam int J_PEN   = 2;

    typedef struct packed {
        logic       en_pc;
        logic       en_ifid;
        logic       flush;
        logic       bubble;
        logic       hazard;
        logic [6:0] cnt;
        logic [1:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pc_low = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    stall_controller_if #(.CNT_W(7)) bus ();

    stall_controller #(
        .DIV_LAT (DIV_LAT),
        .LU_LAT  (LU_LAT),
        .BR_PEN  (BR_PEN),
        .J_PEN   (J_PEN),
        .CNT_W   (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t mk(bit p, bit i, bit f, bit b, bit h, int c, int k);
        exp_t e;
        e.en_pc = p; e.en_ifid = i; e.flush = f; e.bubble = b; e.hazard = h;
        e.cnt = 7'(c); e.kind = 2'(k);
        return e;
    endfunction

    // Reference classification straight from the instruction-field rules.
    function automatic void classify(input logic [31:0] ins, input logic mr, input logic [4:0] xrt,
                                     output int k, output int len);
        int op, fn, rs, rt;
        op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); fn = int'(ins[5:0]);
        k = 0; len = 0;
        if (ins != 32'd0) begin
            if (op == 0 && (fn == 26 || fn == 27)) begin
                k = 1; len = DIV_LAT;
            end else if (mr && xrt != 5'd0 && (int'(xrt) == rs || int'(xrt) == rt)) begin
                k = 2; len = LU_LAT;
            end else if (op == 4 || op == 5) begin
                k = 3; len = BR_PEN;
            end else if (op == 2 || op == 3 || (op == 0 && fn == 8)) begin
                k = 3; len = J_PEN;
            end
        end
    endfunction

    task automatic set_in(input logic [31:0] ins, input logic mr, input logic [4:0] xrt);
        bus.instr_id   = ins;
        bus.ex_memread = mr;
        bus.ex_rt      = xrt;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick(input string tag);
        exp_t        e;
        exp_t        fresh[$];
        logic [13:0] obs, ev;
        int          k, len;
        @(negedge clk);
        fresh = {};
        e = mk(1, 1, 0, 0, 0, 0, 0);
        if (!rst) begin
            e = mk(1, 1, 0, 0, 0, 0, 0);
        end else if (q.size() > 0) begin
            e = q[0];
        end else begin
            classify(bus.instr_id, bus.ex_memread, bus.ex_rt, k, len);
            for (int i = 0; i < len; i++) begin
                if (k == 3) fresh.push_back(mk(0, 1, 1, 0, 1, len - i, k));
                else        fresh.push_back(mk(0, 0, 0, 1, 1, len - i, k));
            end
            if (k == 1 || k == 2) fresh.push_back(mk(1, 1, 0, 0, 0, 0, 0));
            if (fresh.size() > 0) e = fresh[0];
        end
        obs = {bus.en_pc, bus.en_ifid, bus.flush_ifid, bus.bubble_idex, bus.hazard,
               bus.stall_cnt, bus.stall_kind};
        ev  = e;
        total++;
        assert (obs === ev) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (pc,ifid,flush,bubble,hazard,cnt,kind)",
                   tag, obs, ev);
        end
        if (bus.en_pc === 1'b0) pc_low++;
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else begin
            for (int i = 1; i < fresh.size(); i++) q.push_back(fresh[i]);
        end
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    initial begin
        logic [31:0] div_i, beq_i, add_i, ins;
        int          r;

        div_i = rtype(8, 9, 0, 26);
        beq_i = {6'd4, 5'd1, 5'd2, 16'd8};
        add_i = rtype(2, 4, 3, 32);

        // Reset held with a DIV in ID.
        rst = 1'b0;
        set_in(div_i, 1'b0, 5'd0);
        tick("reset0");
        tick("reset1");
        rst = 1'b1;

        // Full divide stall followed by a single release cycle.
        pc_low = 0;
        repeat (33) tick("div");
        total++;
        assert (pc_low === 32) else begin
            bad++;
            $error("FAIL div_len observed=%0d expected=%0d", pc_low, 32);
        end
        set_in(32'd0, 1'b0, 5'd0);
        tick("div_idle");

        // Load-use: lw $2 in EX, add $3,$2,$4 in ID.
        set_in(add_i, 1'b1, 5'd2);
        tick("lu");
        tick("lu_release");
        set_in(add_i, 1'b0, 5'd0);
        tick("lu_proceed");

        // Branch flush.
        set_in(beq_i, 1'b0, 5'd0);
        tick("beq0");
        tick("beq1");
        set_in(32'd0, 1'b0, 5'd0);
        tick("beq_idle");

        // DIV and load-use together: divide wins.
        pc_low = 0;
        set_in(div_i, 1'b1, 5'd8);
        repeat (33) tick("div_prio");
        total++;
        assert (pc_low === 32) else begin
            bad++;
            $error("FAIL div_prio_len observed=%0d expected=%0d", pc_low, 32);
        end
        set_in(32'd0, 1'b0, 5'd0);
        tick("prio_idle");

        // Reset in the middle of a divide, then a full restart.
        set_in(div_i, 1'b0, 5'd0);
        repeat (10) tick("div_pre_rst");
        rst = 1'b0;
        tick("div_rst");
        rst = 1'b1;
        pc_low = 0;
        repeat (33) tick("div_restart");
        total++;
        assert (pc_low === 32) else begin
            bad++;
            $error("FAIL div_restart_len observed=%0d expected=%0d", pc_low, 32);
        end
        set_in(32'd0, 1'b0, 5'd0);
        tick("restart_idle");

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: ins = rtype(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0,
                               26 + int'($urandom_range(0, 1)));
                1: ins = {6'd4 + 6'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 16'($urandom)};
                2: ins = {6'd2 + 6'($urandom_range(0, 1)), 26'($urandom)};
                3: ins = rtype(int'($urandom_range(0, 31)), 0, 0, 8);
                4: ins = 32'd0;
                9: ins = $urandom;
                default: ins = rtype(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                     int'($urandom_range(0, 31)), 32);
            endcase
            set_in(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
            rst = ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0;
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
